// File: rtl/led_pattern_gen_pkg.sv
// Shared mode/state encodings and blink timing for the LED pattern generator.
package led_pattern_gen_pkg;

    localparam int unsigned CLK_FRQ_DEFAULT = 50_000_000;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_1HZ   = 3'd2,
        MODE_2HZ   = 3'd3,
        MODE_4HZ   = 3'd4,
        MODE_07S   = 3'd5,
        MODE_BURST = 3'd6,
        MODE_RSVD  = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        B_ON  = 2'd1,
        B_OFF = 2'd2,
        PAUSE = 2'd3
    } burst_state_t;

    // Half-period lengths in 25 ms ticks.
    localparam logic [7:0] HALF_1HZ    = 8'd20;
    localparam logic [7:0] HALF_2HZ    = 8'd10;
    localparam logic [7:0] HALF_4HZ    = 8'd5;
    localparam logic [7:0] HALF_07S    = 8'd28;
    localparam logic [7:0] BURST_PHASE = 8'd5;

    function automatic logic [7:0] half_ticks(input mode_t m);
        case (m)
            MODE_1HZ: return HALF_1HZ;
            MODE_2HZ: return HALF_2HZ;
            MODE_4HZ: return HALF_4HZ;
            MODE_07S: return HALF_07S;
            default:  return 8'd1;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ch.sv
// One LED channel: registered mode, phase counter and burst sequencer.
module led_pattern_ch
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned PAUSE_TICKS = 140,
    parameter int unsigned ACT_LOW     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic [3:0] burst_n,
    input  logic       sync,
    input  logic       tick,
    output logic       led,
    output logic       burst_done
);

    localparam logic       LED_OFF    = (ACT_LOW != 0);
    localparam logic       LED_ON     = ~LED_OFF;
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_TICKS - 1);
    localparam logic [7:0] BURST_LAST = BURST_PHASE - 8'd1;

    mode_t        mode_in, mode_q, mode_d;
    burst_state_t state_q, state_d;
    logic [7:0]   phase_q, phase_d, half_last;
    logic [3:0]   count_q, count_d, count_inc, bn_q, bn_d;
    logic         led_q, led_d, done_q, done_d;

    assign mode_in   = mode_t'(mode);
    assign half_last = half_ticks(mode_q) - 8'd1;
    assign count_inc = (count_q == 4'hF) ? count_q : count_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            state_q <= IDLE;
            phase_q <= '0;
            count_q <= '0;
            bn_q    <= '0;
            led_q   <= LED_OFF;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            bn_q    <= bn_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    // Restart (sync or mode change) takes priority over any tick in the same cycle.
    always_comb begin
        mode_d  = mode_in;
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        bn_d    = bn_q;
        led_d   = led_q;
        done_d  = 1'b0;
        if (sync || (mode_in != mode_q)) begin
            phase_d = '0;
            count_d = '0;
            state_d = IDLE;
            case (mode_in)
                MODE_ON, MODE_1HZ, MODE_2HZ, MODE_4HZ, MODE_07S: led_d = LED_ON;
                MODE_BURST: begin
                    state_d = B_ON;
                    bn_d    = burst_n;
                    led_d   = (burst_n != 4'd0) ? LED_ON : LED_OFF;
                end
                default: led_d = LED_OFF;
            endcase
        end else begin
            case (mode_q)
                MODE_ON: led_d = LED_ON;
                MODE_1HZ, MODE_2HZ, MODE_4HZ, MODE_07S: begin
                    if (tick) begin
                        if (phase_q == half_last) begin
                            phase_d = '0;
                            led_d   = ~led_q;
                        end else begin
                            phase_d = phase_q + 8'd1;
                        end
                    end
                end
                MODE_BURST: begin
                    if (tick) begin
                        case (state_q)
                            B_ON: begin
                                if (phase_q == BURST_LAST) begin
                                    phase_d = '0;
                                    state_d = B_OFF;
                                    led_d   = LED_OFF;
                                end else begin
                                    phase_d = phase_q + 8'd1;
                                end
                            end
                            B_OFF: begin
                                if (phase_q == BURST_LAST) begin
                                    phase_d = '0;
                                    count_d = count_inc;
                                    if (count_inc == bn_q) begin
                                        state_d = PAUSE;
                                        done_d  = 1'b1;
                                    end else begin
                                        state_d = B_ON;
                                        led_d   = (bn_q != 4'd0) ? LED_ON : LED_OFF;
                                    end
                                end else begin
                                    phase_d = phase_q + 8'd1;
                                end
                            end
                            PAUSE: begin
                                if (phase_q == PAUSE_LAST) begin
                                    phase_d = '0;
                                    count_d = '0;
                                    state_d = B_ON;
                                    bn_d    = burst_n;
                                    led_d   = (burst_n != 4'd0) ? LED_ON : LED_OFF;
                                end else begin
                                    phase_d = phase_q + 8'd1;
                                end
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
                default: led_d = LED_OFF;
            endcase
        end
    end

    assign led        = led_q;
    assign burst_done = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared 25 ms prescaler feeding NUM_CH channels.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned CLK_FRQ     = CLK_FRQ_DEFAULT,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned PAUSE_TICKS = 140,
    parameter int unsigned ACT_LOW     = 0
) (
    input  logic                  SYSCLK,
    input  logic                  RESET_N,
    input  logic [3*NUM_CH-1:0]   MODE,
    input  logic [4*NUM_CH-1:0]   BURST_N,
    input  logic                  SYNC,
    output logic [NUM_CH-1:0]     LED,
    output logic [NUM_CH-1:0]     BURST_DONE,
    output logic                  TICK
);

    localparam int unsigned   DIV      = CLK_FRQ / 40;
    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (SYNC || (cnt == DIV_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gated with reset so TICK stays low in reset even when DIV is 1.
    assign TICK = RESET_N && (cnt == DIV_LAST);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        led_pattern_ch #(
            .PAUSE_TICKS (PAUSE_TICKS),
            .ACT_LOW     (ACT_LOW)
        ) u_ch (
            .clk        (SYSCLK),
            .rst_n      (RESET_N),
            .mode       (MODE[3*n +: 3]),
            .burst_n    (BURST_N[4*n +: 4]),
            .sync       (SYNC),
            .tick       (TICK),
            .led        (LED[n]),
            .burst_done (BURST_DONE[n])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen at CLK_FRQ=400 (TICK every 10 cycles), both LED polarities.
module tb_led_pattern_gen;

    localparam int NUM_CH = 8;
    localparam int DIV    = 10;
    localparam int PAUSE  = 140;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] mode;
    logic [31:0] burst_n;
    logic        sync;
    logic [7:0]  led_hi, led_lo, done_hi, done_lo;
    logic        tick_hi, tick_lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_FRQ (400), .NUM_CH (NUM_CH), .PAUSE_TICKS (PAUSE), .ACT_LOW (0)
    ) dut_hi (
        .SYSCLK (clk), .RESET_N (rst_n), .MODE (mode), .BURST_N (burst_n), .SYNC (sync),
        .LED (led_hi), .BURST_DONE (done_hi), .TICK (tick_hi)
    );

    led_pattern_gen #(
        .CLK_FRQ (400), .NUM_CH (NUM_CH), .PAUSE_TICKS (PAUSE), .ACT_LOW (1)
    ) dut_lo (
        .SYSCLK (clk), .RESET_N (rst_n), .MODE (mode), .BURST_N (burst_n), .SYNC (sync),
        .LED (led_lo), .BURST_DONE (done_lo), .TICK (tick_lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: LED level derived from ticks elapsed since the channel's last restart.
    function automatic logic model_lit(input logic [2:0] m, input int n, input int bn);
        int per, ph;
        case (m)
            3'd1: return 1'b1;
            3'd2: return ((n / 20) % 2) == 0;
            3'd3: return ((n / 10) % 2) == 0;
            3'd4: return ((n / 5) % 2) == 0;
            3'd5: return ((n / 28) % 2) == 0;
            3'd6: begin
                if (bn == 0) return 1'b0;
                per = 10 * bn + PAUSE;
                ph  = n % per;
                return (ph < 10 * bn) && ((ph % 10) < 5);
            end
            default: return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] lit;
        logic [7:0] lit_lo;
        logic [7:0] done;
        logic       tick;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_push, e_pop;
    int         m_pcnt;
    logic [2:0] m_mode [NUM_CH];
    int         m_n    [NUM_CH];
    int         m_bn   [NUM_CH];
    logic [7:0] m_done;
    logic       m_tick;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pcnt = 0;
            m_done = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 3'd0;
                m_n[c]    = 0;
                m_bn[c]   = 0;
            end
        end else begin
            m_tick = (m_pcnt == DIV - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                m_done[c] = 1'b0;
                if (sync || (mode[3*c +: 3] != m_mode[c])) begin
                    m_mode[c] = mode[3*c +: 3];
                    m_n[c]    = 0;
                    m_bn[c]   = int'(burst_n[4*c +: 4]);
                end else if (m_tick && m_mode[c] >= 3'd2 && m_mode[c] <= 3'd6) begin
                    m_n[c]++;
                    if (m_mode[c] == 3'd6 && m_bn[c] != 0 &&
                        (m_n[c] % (10 * m_bn[c] + PAUSE)) == 10 * m_bn[c])
                        m_done[c] = 1'b1;
                end
            end
            m_pcnt = (sync || m_pcnt == DIV - 1) ? 0 : m_pcnt + 1;
        end
        for (int c = 0; c < NUM_CH; c++)
            e_push.lit[c] = model_lit(m_mode[c], m_n[c], m_bn[c]);
        e_push.lit_lo = ~e_push.lit;
        e_push.done   = m_done;
        e_push.tick   = rst_n && (m_pcnt == DIV - 1);
        sb.push_back(e_push);
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_pop = sb.pop_front();
            if (!rst_n) begin
                check("rst_led_hi", led_hi, 32'h00);
                check("rst_led_lo", led_lo, 32'hFF);
                check("rst_done", done_hi | done_lo, 32'h00);
                check("rst_tick", tick_hi | tick_lo, 32'h0);
            end else begin
                check("sb_led_hi", led_hi, e_pop.lit);
                check("sb_led_lo", led_lo, e_pop.lit_lo);
                check("sb_done_hi", done_hi, e_pop.done);
                check("sb_done_lo", done_lo, e_pop.done);
                check("sb_tick_hi", tick_hi, e_pop.tick);
                check("sb_tick_lo", tick_lo, e_pop.tick);
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n   = 1'b0;
        mode    = '0;
        burst_n = '0;
        sync    = 1'b0;
        step(3);
        check("reset_led_hi", led_hi, 32'h00);
        check("reset_led_lo", led_lo, 32'hFF);
        check("reset_tick", tick_hi, 32'h0);
        rst_n = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("tick_seq", tick_hi, ((k % 10) == 9) ? 32'h1 : 32'h0);
        end
        check("all_off", led_hi, 32'h00);

        mode[2:0] = 3'd4;
        step(1);
        check("ch0_start_on", led_hi[0], 32'h1);
        step(150);

        burst_n[7:4] = 4'd3;
        mode[5:3]    = 3'd6;
        sync         = 1'b1;
        step(1);
        sync = 1'b0;
        check("burst_start_on", led_hi[1], 32'h1);
        check("sync_ch0_on", led_hi[0], 32'h1);
        step(49);
        check("ch0_pre_toggle", led_hi[0], 32'h1);
        step(1);
        check("ch0_toggle_50", led_hi[0], 32'h0);
        step(249);
        check("burst_done_early", done_hi[1], 32'h0);
        step(1);
        check("burst_done_300", done_hi[1], 32'h1);
        check("burst_pause_off", led_hi[1], 32'h0);
        step(1);
        check("burst_done_single", done_hi[1], 32'h0);
        step(1398);
        check("pause_end_off", led_hi[1], 32'h0);
        step(1);
        check("pause_end_on", led_hi[1], 32'h1);

        mode[8:6] = 3'd2;
        step(13);
        mode[11:9] = 3'd2;
        step(7);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("sync_ch23_on", led_hi[3:2], 32'h3);
        step(199);
        check("ch23_hold", led_hi[3:2], 32'h3);
        step(1);
        check("ch23_toggle", led_hi[3:2], 32'h0);
        step(200);
        check("ch23_toggle2", led_hi[3:2], 32'h3);

        mode[14:12] = 3'd3;
        step(25);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tick_hi) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check("tick_found", found, 32'h1);
        mode[14:12] = 3'd5;
        step(1);
        check("chg_on_tick_on", led_hi[4], 32'h1);
        step(279);
        check("chg_hold_279", led_hi[4], 32'h1);
        step(1);
        check("chg_toggle_280", led_hi[4], 32'h0);

        burst_n[23:20] = 4'd0;
        mode[17:15]    = 3'd6;
        mode[20:18]    = 3'd7;
        mode[23:21]    = 3'd1;
        step(1);
        check("static_ch567", led_hi[7:5], 32'h4);
        step(400);
        check("burst0_off", led_hi[5], 32'h0);
        check("static_hold", led_hi[7:6], 32'h2);

        step(23);
        rst_n = 1'b0;
        #1;
        check("async_rst_led_hi", led_hi, 32'h00);
        check("async_rst_led_lo", led_lo, 32'hFF);
        check("async_rst_done", done_hi, 32'h00);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_ch1_on", led_hi[1], 32'h1);
        check("post_rst_ch5_off", led_hi[5], 32'h0);
        step(1800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CLK_FRQ, default `CLK_FRQ, SYSCLK cycles per second; SHALL be a multiple of 40 and at least 40.
REQ-002 Parameter NUM_CH, default 8, number of independent LED channels (1..32).
REQ-003 Parameter PAUSE_TICKS, default 140, burst-mode pause length in 25 ms ticks (1..255).
REQ-004 Parameter ACT_LOW, default 0, 1 = LED output active-low.
REQ-005 SYSCLK  input  1  single system clock, all logic on rising edge.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 MODE  input  3*NUM_CH  per-channel mode, channel n at [3n+2:3n].
REQ-008 BURST_N  input  4*NUM_CH  per-channel pulse count for burst mode.
REQ-009 SYNC  input  1  one-cycle pulse, realigns all channel phases.
REQ-010 LED  output  NUM_CH  registered LED drive, polarity per ACT_LOW.
REQ-011 BURST_DONE  output  NUM_CH  one-cycle pulse when a channel enters its pause.
REQ-012 TICK  output  1  one-cycle 25 ms timebase strobe.

Function
REQ-013 Prescaler counts 0..CLK_FRQ/40-1 and wraps; TICK SHALL be high for the one cycle in which the count equals CLK_FRQ/40-1.
REQ-014 Mode encoding: 0 OFF, 1 ON, 2 1 Hz (20 ticks on/20 off), 3 2 Hz (10/10), 4 4 Hz (5/5), 5 0.7 s toggle (28/28), 6 burst, 7 reserved (treated as OFF).
REQ-015 "On" means LED = ~ACT_LOW, "off" means LED = ACT_LOW.
REQ-016 Each channel registers MODE internally; a change in its MODE field SHALL clear its phase counter and state and, in every blink mode, drive LED on in the following cycle.
REQ-017 Blink modes: the phase counter advances on TICK; on reaching half-period-1, LED toggles on the same TICK and the counter returns to 0.
REQ-018 Burst FSM states: IDLE, B_ON, B_OFF, PAUSE; entry goes to B_ON with pulse count 0; B_ON and B_OFF each last 5 ticks; B_OFF exit increments the count and goes to PAUSE when count = BURST_N, else to B_ON.
REQ-019 PAUSE holds LED off for PAUSE_TICKS ticks, then returns to B_ON with count 0; BURST_DONE pulses in the first cycle of PAUSE.
REQ-020 BURST_N = 0 in burst mode SHALL hold LED off with no BURST_DONE; BURST_N is sampled only on B_ON entry.
REQ-021 SYNC SHALL clear the prescaler and every channel phase/state, as on a mode change; if SYNC coincides with TICK, SYNC wins and no toggle occurs.
REQ-022 A mode change coinciding with TICK SHALL take the restart path, not the toggle.
REQ-023 OFF/ON/reserved modes SHALL be static and ignore TICK.
REQ-024 Counters: prescaler ceil(log2(CLK_FRQ/40)) bits, phase 8 bits, pulse count 4 bits; none SHALL wrap past its terminal value.

Reset
REQ-025 RESET_N low SHALL asynchronously force: LED = ACT_LOW on all channels, BURST_DONE = 0, TICK = 0, prescaler/phase/count = 0, FSM = IDLE, registered modes = 0 (OFF).
REQ-026 Reset deassertion mid-pattern SHALL restart every channel as a mode change from OFF in the first cycle after release.

Structure
REQ-027 Mode encodings, `ON/`OFF and `CLK_FRQ SHALL live in baseboard_define.v; the half-period tick constants SHALL be localparams.
REQ-028 Sub-module led_pattern_ch implements one channel (mode register, phase counter, burst FSM) and SHALL be generated NUM_CH times; the prescaler is shared in the top level.

Verification (CLK_FRQ=400, TICK every 10 cycles)
REQ-029 Reset release with all MODE=0 -> LED=0x00, TICK first asserted in cycle 10, then every 10 cycles.
REQ-030 Channel 0 MODE=4 -> LED[0] on for the next cycle, then toggles every 50 cycles; ACT_LOW=1 inverts all levels.
REQ-031 Channel 1 MODE=6, BURST_N=3 -> 3 pulses of 50 on/50 off, BURST_DONE[1] one cycle at 300, LED off 1400 cycles, then the pattern repeats.
REQ-032 Channels 2 and 3 set to MODE=2 at different times, then SYNC pulsed -> both LEDs on in the next cycle and toggle together every 200 cycles.
REQ-033 MODE changed 3->5 in the cycle of TICK -> no toggle, restart on, next toggle after 280 cycles.
REQ-034 RESET_N asserted mid-burst -> LED and BURST_DONE immediately inactive; FSM in IDLE after release.
